// File: rtl/rom_oscillator_cos.sv
// rtl/rom_oscillator_cos.sv - fixed-frequency cosine generator stepping through an elaboration-time ROM
module rom_oscillator_cos #(
    parameter int  INT_DATA_WIDTH    = 32,
    parameter real REAL_IN_FREQ_MHZ  = 125.0,
    parameter real REAL_OUT_FREQ_MHZ = 25.0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_valid,
    output logic                             o_valid,
    output logic signed [INT_DATA_WIDTH-1:0] o_cos
);

    localparam real RATIO = REAL_IN_FREQ_MHZ / REAL_OUT_FREQ_MHZ;
    // Round the frequency ratio to the nearest whole number of samples per period.
    localparam int  N     = $rtoi(RATIO + 0.5);
    localparam int  IDX_W = (N < 2) ? 1 : $clog2(N);
    localparam real TWO_PI = 6.283185307179586;
    // Full-scale amplitude is symmetric so the most negative code never appears.
    localparam real AMP   = (2.0 ** (INT_DATA_WIDTH - 1)) - 1.0;

    if (N < 2 || N > 4096) begin : g_bad_depth
        $fatal(1, "rom_oscillator_cos: ROM depth out of range 2..4096");
    end
    if (INT_DATA_WIDTH < 8 || INT_DATA_WIDTH > 32) begin : g_bad_width
        $fatal(1, "rom_oscillator_cos: INT_DATA_WIDTH out of range 8..32");
    end

    logic signed [INT_DATA_WIDTH-1:0] rom [N];

    // One period of cosine, rounded half away from zero, fixed at elaboration.
    for (genvar k = 0; k < N; k++) begin : g_rom
        localparam real SAMPLE = AMP * $cos(TWO_PI * real'(k) / real'(N));
        localparam int  ROUNDED = (SAMPLE >= 0.0) ? $rtoi(SAMPLE + 0.5) : $rtoi(SAMPLE - 0.5);
        assign rom[k] = INT_DATA_WIDTH'(ROUNDED);
    end

    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic                             valid_q, valid_d;
    logic signed [INT_DATA_WIDTH-1:0] cos_q, cos_d;

    // Advance phase only on accepted strobes; output holds its sample during gaps.
    always_comb begin
        idx_d   = idx_q;
        valid_d = 1'b0;
        cos_d   = cos_q;
        if (i_valid) begin
            cos_d   = rom[idx_q];
            valid_d = 1'b1;
            idx_d   = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset taking priority over the strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
            cos_q   <= '0;
        end else begin
            idx_q   <= idx_d;
            valid_q <= valid_d;
            cos_q   <= cos_d;
        end
    end

    assign o_valid = valid_q;
    assign o_cos   = cos_q;

endmodule

// File: tb/tb_rom_oscillator_cos.sv
// tb/tb_rom_oscillator_cos.sv - directed self-checking bench for rom_oscillator_cos
module tb_rom_oscillator_cos;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        va, vb, vc;
    logic signed [31:0] ca;
    logic signed [15:0] cb, cc;

    int total = 0;
    int bad   = 0;

    longint exp_a [5];
    longint exp_b [4];

    always #5 clk = ~clk;

    rom_oscillator_cos #(.INT_DATA_WIDTH(32), .REAL_IN_FREQ_MHZ(125.0), .REAL_OUT_FREQ_MHZ(25.0)) u_a (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_valid(va), .o_cos(ca));
    rom_oscillator_cos #(.INT_DATA_WIDTH(16), .REAL_IN_FREQ_MHZ(125.0), .REAL_OUT_FREQ_MHZ(31.25)) u_b (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_valid(vb), .o_cos(cb));
    rom_oscillator_cos #(.INT_DATA_WIDTH(16), .REAL_IN_FREQ_MHZ(125.0), .REAL_OUT_FREQ_MHZ(30.0)) u_c (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_valid(vc), .o_cos(cc));

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ev, input longint ea, input longint eb);
        chk({tag, "_va"}, longint'(va), longint'(ev));
        chk({tag, "_vb"}, longint'(vb), longint'(ev));
        chk({tag, "_vc"}, longint'(vc), longint'(ev));
        chk({tag, "_ca"}, longint'(ca), ea);
        chk({tag, "_cb"}, longint'(cb), eb);
        chk({tag, "_cc"}, longint'(cc), eb);
    endtask

    logic   pat [7];
    int     k;
    longint last_a, last_b;

    initial begin
        exp_a[0] = 2147483647;
        exp_a[1] = 663608942;
        exp_a[2] = -1737350766;
        exp_a[3] = -1737350766;
        exp_a[4] = 663608942;
        exp_b[0] = 32767;
        exp_b[1] = 0;
        exp_b[2] = -32767;
        exp_b[3] = 0;

        // reset held with strobe asserted
        rst_n   = 1'b0;
        i_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("reset", 1'b0, 0, 0);
        end

        // continuous stream of 101 strobes
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 101; i++) begin
            tick();
            chk_all("stream", 1'b1, exp_a[k % 5], exp_b[k % 4]);
            k++;
        end
        chk("stream_last_is_idx0", longint'(ca), 2147483647);

        // strobe drops: valid falls one cycle later, sample holds
        i_valid = 1'b0;
        tick();
        chk_all("drop", 1'b0, exp_a[(k - 1) % 5], exp_b[(k - 1) % 4]);
        tick();
        chk_all("drop_hold", 1'b0, exp_a[(k - 1) % 5], exp_b[(k - 1) % 4]);

        // gapped strobe from a fresh reset
        rst_n = 1'b0;
        tick();
        chk_all("gap_rst", 1'b0, 0, 0);
        rst_n = 1'b1;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        k = 0;
        last_a = 0;
        last_b = 0;
        for (int i = 0; i < 7; i++) begin
            i_valid = pat[i];
            tick();
            if (pat[i]) begin
                last_a = exp_a[k % 5];
                last_b = exp_b[k % 4];
                k++;
            end
            chk_all("gap", pat[i], last_a, last_b);
        end
        chk("gap_count", longint'(k), 4);
        chk("gap_final_idx3", longint'(ca), -1737350766);

        // mid-stream reset after three samples
        i_valid = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("pre_mid", 1'b1, exp_a[i], exp_b[i]);
        end
        rst_n = 1'b0;
        tick();
        chk_all("mid_rst", 1'b0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_all("post_mid", 1'b1, exp_a[i % 5], exp_b[i % 4]);
        end

        i_valid = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_oscillator_cos.md
Name: rom_oscillator_cos

Overview:
- Fixed-frequency cosine generator: one full period of cos is held in a ROM computed at elaboration; an address counter steps through it once per valid input strobe.
- Produces a signed sinusoid at REAL_OUT_FREQ_MHZ when i_valid is asserted every cycle of a REAL_IN_FREQ_MHZ clock.
- Used as local oscillator / reference tone source for mixers and demodulators in the DSP chain.

Parameters:
- INT_DATA_WIDTH, 32, width of signed output sample (range 8..32).
- REAL_IN_FREQ_MHZ, 125.0, sample (clock/strobe) rate in MHz.
- REAL_OUT_FREQ_MHZ, 25.0, generated cosine frequency in MHz.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active low.
- i_valid  in  1  step strobe; one ROM sample emitted per cycle it is high.
- o_valid  out  1  o_cos holds a new sample this cycle.
- o_cos  out  INT_DATA_WIDTH  signed two's-complement cosine sample.

Behaviour:
- Reset: synchronous, active low. While rst_n=0 at a rising edge: phase index=0, o_valid=0, o_cos=0. Reset has priority over i_valid. The first valid after reset yields the index-0 sample.
- ROM depth: N = round(REAL_IN_FREQ_MHZ / REAL_OUT_FREQ_MHZ), computed at elaboration. Defaults give N=5.
- Parameter checks: elaboration fails if N < 2 or N > 4096.
- A non-integer ratio is rounded to N; the resulting frequency error is accepted.
- ROM contents: ROM[k] = round(A * cos(2*pi*k/N)) for k=0..N-1.
  - A = 2^(INT_DATA_WIDTH-1) - 1.
  - Rounding is half away from zero.
  - All entries lie within ±A; -2^(W-1) never occurs.
  - Content is constant, computed with real math at elaboration; no runtime writes.
- Datapath, per rising edge with rst_n=1:
  - i_valid=1: o_cos <= ROM[idx]; o_valid <= 1; idx <= (idx==N-1) ? 0 : idx+1.
  - i_valid=0: idx holds; o_cos holds its last value; o_valid <= 0.
- Latency: exactly 1 clock from i_valid to o_valid/o_cos. Continuous i_valid gives continuous o_valid.
- Phase continuity: gaps in i_valid do not skip or advance phase. The output sequence is a function of the count of accepted strobes only.
- Wrap-around: after ROM[N-1] the next sample is ROM[0], with no bubble.
- Index register is ceil(log2(N)) bits; no out-of-range address is ever presented.
- Reset mid-stream: the next valid after reset restarts at ROM[0].
- No backpressure; o_valid is not gated by any downstream ready.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with i_valid=1 -> o_valid=0 and o_cos=0 throughout.
- Continuous stream, defaults (W=32, N=5), i_valid=1 for 101 cycles -> o_valid high for 101 cycles starting 1 cycle late. o_cos repeats with period 5: 2147483647, 663608942, -1737350766, -1737350766, 663608942 (±1 LSB). The last sample is the index-0 value 2147483647. o_valid drops 1 cycle after i_valid drops, and o_cos then holds.
- Gapped strobe: i_valid pattern 1,0,0,1,1,0,1 -> o_valid 1 cycle delayed. o_cos sequence is ROM[0], ROM[1], ROM[2], ROM[3], with no skipped phase; o_cos holds during gaps.
- Mid-stream reset: after 3 valid samples, pulse rst_n=0 for 1 cycle, then resume i_valid=1 -> first post-reset sample is 2147483647.
- Alternate parameters W=16, IN=125.0, OUT=31.25 (N=4), continuous valid -> o_cos = 32767, 0, -32767, 0, repeating.
- Non-integer ratio W=16, IN=125.0, OUT=30.0 -> N=4 (4.1667 rounded); same sequence as the previous scenario.
